// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared data RAM.
//
// Handshake: a requester raises reqN and holds weN/addrN/wdataN stable until it
// sees ackN high for one cycle. It updates reqN on the edge where it sees ackN.
// If reqN is still high in the following cycle, that is a new transaction.
// rdataN is valid in the ackN cycle. Dropping reqN before ackN is a protocol
// violation, but the latched transaction still completes and is acked.
interface dm_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              owner;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic              Mem_Write;
  logic [ADDR_W-1:0] DM_Addr;
  logic [DATA_W-1:0] M_W_Data;
  logic [DATA_W-1:0] M_R_Data;
  logic [1:0]        state_dbg;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, M_R_Data,
    output ack0, ack1, rdata0, rdata1, busy, owner, cnt0, cnt1,
           Mem_Write, DM_Addr, M_W_Data, state_dbg
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, M_R_Data,
    input  ack0, ack1, rdata0, rdata1, busy, owner, cnt0, cnt1,
           Mem_Write, DM_Addr, M_W_Data, state_dbg
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 64 x 32 data RAM.
// Each transaction takes IDLE -> ACCESS -> RESP, with the ack pulse in RESP.
module dm_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              winner;

  // Next-state logic: grant in IDLE, capture read data in ACCESS, count in RESP.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    owner_d  = owner_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    // On a tie the port that did not win last time goes next.
    winner   = (bus.req0 & bus.req1) ? ~owner_q : bus.req1;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          owner_d = winner;
          we_d    = winner ? bus.we1    : bus.we0;
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Writes capture the old word too; requesters ignore it.
        if (owner_q) rdata1_d = bus.M_R_Data;
        else         rdata0_d = bus.M_R_Data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_q) cnt1_d = cnt1_q + CNT_W'(1);
        else         cnt0_d = cnt0_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      owner_q  <= 1'b1;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      owner_q  <= owner_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Reset gates the write strobe directly so a reset during ACCESS never writes.
  assign bus.Mem_Write = (state_q == S_ACCESS) & we_q & ~rst;
  assign bus.DM_Addr   = addr_q;
  assign bus.M_W_Data  = wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ack0      = (state_q == S_RESP) & ~owner_q;
  assign bus.ack1      = (state_q == S_RESP) &  owner_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.owner     = owner_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
  assign bus.state_dbg = state_q;

endmodule
